// File: rtl/seg7_pkg.sv
// Shared constants, state encoding and helpers for the 4-digit 7-segment scan controller.
package seg7_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Segment patterns, abc_defg, active low
  localparam logic [6:0] SEG_0     = 7'b000_0001;
  localparam logic [6:0] SEG_1     = 7'b100_1111;
  localparam logic [6:0] SEG_2     = 7'b001_0010;
  localparam logic [6:0] SEG_3     = 7'b000_0110;
  localparam logic [6:0] SEG_4     = 7'b100_1100;
  localparam logic [6:0] SEG_5     = 7'b010_0100;
  localparam logic [6:0] SEG_6     = 7'b010_0000;
  localparam logic [6:0] SEG_7     = 7'b000_1111;
  localparam logic [6:0] SEG_8     = 7'b000_0000;
  localparam logic [6:0] SEG_9     = 7'b000_0100;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_t;

  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_code = SEG_0;
      4'd1:    seg_code = SEG_1;
      4'd2:    seg_code = SEG_2;
      4'd3:    seg_code = SEG_3;
      4'd4:    seg_code = SEG_4;
      4'd5:    seg_code = SEG_5;
      4'd6:    seg_code = SEG_6;
      4'd7:    seg_code = SEG_7;
      4'd8:    seg_code = SEG_8;
      4'd9:    seg_code = SEG_9;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  // Add 3 to every BCD nibble >= 5 ahead of the shift
  function automatic logic [19:0] bcd_adjust(input logic [19:0] bcd);
    logic [19:0] res;
    res = bcd;
    for (int i = 0; i < 5; i++) begin
      if (res[i*4 +: 4] >= 4'd5) res[i*4 +: 4] = res[i*4 +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 converter: captures Value on Load, produces four display
// digits (with optional leading-zero blanking) and an overflow flag after 17 busy cycles.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter bit LZB = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [15:0]      Value,
  input  logic             Load,
  output logic             Busy,
  output logic             Ovf,
  output logic [3:0][3:0]  digits
);

  conv_state_t state_q, state_d;
  logic [15:0]     bin_q;
  logic [19:0]     bcd_q;
  logic [3:0]      cnt_q;
  logic [35:0]     shifted;
  logic [3:0][3:0] commit_digits;

  assign shifted = {bcd_adjust(bcd_q), bin_q} << 1;
  assign Busy    = (state_q != ST_IDLE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (Load) state_d = ST_CONV;
      ST_CONV:   if (cnt_q == 4'd15) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Blank every digit above the most significant nonzero one; digit 0 always shows
  always_comb begin
    commit_digits = {bcd_q[15:12], bcd_q[11:8], bcd_q[7:4], bcd_q[3:0]};
    if (LZB && bcd_q[15:12] == 4'd0) begin
      commit_digits[3] = BLANK_CODE;
      if (bcd_q[11:8] == 4'd0) begin
        commit_digits[2] = BLANK_CODE;
        if (bcd_q[7:4] == 4'd0) commit_digits[1] = BLANK_CODE;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      Ovf    <= 1'b0;
      digits <= {4{BLANK_CODE}};
    end else begin
      case (state_q)
        ST_IDLE: if (Load) begin
          bin_q <= Value;
          bcd_q <= '0;
          cnt_q <= '0;
        end
        ST_CONV: begin
          bcd_q <= shifted[35:16];
          bin_q <= shifted[15:0];
          cnt_q <= cnt_q + 4'd1;
        end
        ST_COMMIT: begin
          if (bcd_q[19:16] != 4'd0) begin
            Ovf    <= 1'b1;
            digits <= {4{BLANK_CODE}};
          end else begin
            Ovf    <= 1'b0;
            digits <= commit_digits;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// 4-digit multiplexed common-anode display driver: converter plus prescaled digit
// scan with registered active-low anode and segment outputs.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit LZB         = 1'b1,
  parameter int DIV_W       = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Value,
  input  logic        Load,
  output logic        Busy,
  output logic        Ovf,
  output logic [3:0]  An,
  output logic [6:0]  Disp
);

  logic [3:0][3:0]  digits;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       idx_q, idx_d;
  logic             wrap;

  bin2bcd_seq #(.LZB(LZB)) u_conv (
    .Clk    (Clk),
    .Reset  (Reset),
    .Value  (Value),
    .Load   (Load),
    .Busy   (Busy),
    .Ovf    (Ovf),
    .digits (digits)
  );

  assign wrap  = (div_q == DIV_W'(REFRESH_DIV - 1));
  assign idx_d = wrap ? idx_q + 2'd1 : idx_q;

  // Outputs follow the index being entered so An and Disp switch on the wrap edge
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_q <= '0;
      idx_q <= '0;
      An    <= 4'b1111;
      Disp  <= SEG_BLANK;
    end else begin
      div_q <= wrap ? '0 : div_q + 1'b1;
      idx_q <= idx_d;
      An    <= ~(4'b0001 << idx_d);
      Disp  <= seg_code(digits[idx_d]);
    end
  end

endmodule
